// File: rtl/modulo_debounce_botoes_pkg.sv
// -----------------------------------------------------------------------------
// modulo_debounce_botoes_pkg
// Shared definitions for the push-button debouncer:
//   - estado_t : per-channel FSM state encoding
//   - TEMPO_ESTAVEL_50MHZ : default confirmation window (10 ms at 50 MHz)
//   - CONT_W_PADRAO : default counter width able to hold that window
// -----------------------------------------------------------------------------
package modulo_debounce_botoes_pkg;

  typedef enum logic [1:0] {
    SOLTO        = 2'b00,  // released, idle
    CONF_PRESS   = 2'b01,  // candidate press, counting stable samples
    PRESSIONADO  = 2'b10,  // pressed, accepted
    CONF_SOLTURA = 2'b11   // candidate release, counting stable samples
  } estado_t;

  localparam int TEMPO_ESTAVEL_50MHZ = 500000;
  localparam int CONT_W_PADRAO       = 19;

  // Debounced level is asserted while the key is considered held, including
  // while a release is still being confirmed.
  function automatic logic nivel_de(input estado_t e);
    return (e == PRESSIONADO) || (e == CONF_SOLTURA);
  endfunction

endpackage

// File: rtl/modulo_debounce_botoes_canal.sv
// -----------------------------------------------------------------------------
// modulo_debounce_canal
// One debounce channel: 2-FF synchroniser, confirmation FSM with counter and
// three registered outputs.
// Ports:
//   clk         in  board clock, rising edge
//   clr         in  asynchronous active-high reset
//   botao_in    in  raw key, asynchronous to clk
//   nivel_out   out debounced level (1 = pressed)
//   pulso_out   out one-clk pulse per accepted press
//   soltura_out out one-clk pulse per accepted release
//   estado_dbg  out current FSM state, for observation only
// -----------------------------------------------------------------------------
module modulo_debounce_canal
  import modulo_debounce_botoes_pkg::*;
#(
  parameter int TEMPO_ESTAVEL = TEMPO_ESTAVEL_50MHZ,
  parameter int ATIVO_BAIXO   = 1,
  parameter int CONT_W        = CONT_W_PADRAO
) (
  input  logic    clk,
  input  logic    clr,
  input  logic    botao_in,
  output logic    nivel_out,
  output logic    pulso_out,
  output logic    soltura_out,
  output estado_t estado_dbg
);

  if (TEMPO_ESTAVEL < 2) begin : g_err_tempo
    $error("TEMPO_ESTAVEL must be at least 2");
  end
  if ((longint'(1) << CONT_W) <= longint'(TEMPO_ESTAVEL)) begin : g_err_cont
    $error("CONT_W too narrow for TEMPO_ESTAVEL");
  end

  // Raw value of an idle key; also the value the synchroniser resets to.
  localparam logic L_REPOUSO = (ATIVO_BAIXO != 0);
  localparam logic [CONT_W-1:0] L_CNT_MAX = CONT_W'(TEMPO_ESTAVEL - 1);
  localparam logic [CONT_W-1:0] L_UM      = CONT_W'(1);

  logic              r_sync1, r_sync2;
  estado_t           r_estado, w_estado_prox;
  logic [CONT_W-1:0] r_cnt, w_cnt_prox;
  logic              r_nivel, r_pulso, r_soltura;
  logic              w_pulso_prox, w_soltura_prox;
  logic              w_p;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sync1 <= L_REPOUSO;
      r_sync2 <= L_REPOUSO;
    end else begin
      r_sync1 <= botao_in;
      r_sync2 <= r_sync1;
    end
  end

  // Normalised sample: 1 means pressed regardless of key polarity.
  assign w_p = r_sync2 ^ L_REPOUSO;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_estado  <= SOLTO;
      r_cnt     <= '0;
      r_nivel   <= 1'b0;
      r_pulso   <= 1'b0;
      r_soltura <= 1'b0;
    end else begin
      r_estado  <= w_estado_prox;
      r_cnt     <= w_cnt_prox;
      // Outputs follow the next state so they line up with the state change.
      r_nivel   <= nivel_de(w_estado_prox);
      r_pulso   <= w_pulso_prox;
      r_soltura <= w_soltura_prox;
    end
  end

  always_comb begin
    w_estado_prox  = r_estado;
    w_cnt_prox     = r_cnt;
    w_pulso_prox   = 1'b0;
    w_soltura_prox = 1'b0;
    case (r_estado)
      SOLTO: begin
        if (w_p) begin
          w_estado_prox = CONF_PRESS;
          w_cnt_prox    = L_UM;
        end else begin
          w_cnt_prox    = '0;
        end
      end
      CONF_PRESS: begin
        if (!w_p) begin
          // Bounce: drop the candidate press entirely.
          w_estado_prox = SOLTO;
          w_cnt_prox    = '0;
        end else if (r_cnt == L_CNT_MAX) begin
          w_estado_prox = PRESSIONADO;
          w_cnt_prox    = '0;
          w_pulso_prox  = 1'b1;
        end else begin
          w_cnt_prox    = r_cnt + L_UM;
        end
      end
      PRESSIONADO: begin
        if (!w_p) begin
          w_estado_prox = CONF_SOLTURA;
          w_cnt_prox    = L_UM;
        end
      end
      CONF_SOLTURA: begin
        if (w_p) begin
          w_estado_prox  = PRESSIONADO;
          w_cnt_prox     = '0;
        end else if (r_cnt == L_CNT_MAX) begin
          w_estado_prox  = SOLTO;
          w_cnt_prox     = '0;
          w_soltura_prox = 1'b1;
        end else begin
          w_cnt_prox     = r_cnt + L_UM;
        end
      end
      default: begin
        w_estado_prox = SOLTO;
        w_cnt_prox    = '0;
      end
    endcase
  end

  assign nivel_out   = r_nivel;
  assign pulso_out   = r_pulso;
  assign soltura_out = r_soltura;
  assign estado_dbg  = r_estado;

endmodule

// File: rtl/modulo_debounce_botoes.sv
// -----------------------------------------------------------------------------
// modulo_debounce_botoes
// Debounces NUM_BOTOES independent board keys.
// Ports:
//   clk         in  50 MHz board clock, rising edge
//   clr         in  asynchronous active-high reset
//   botao_in    in  [NUM_BOTOES] raw keys
//   nivel_out   out [NUM_BOTOES] debounced levels (1 = pressed)
//   pulso_out   out [NUM_BOTOES] one-clk press pulses
//   soltura_out out [NUM_BOTOES] one-clk release pulses
//   estado_dbg  out [2*NUM_BOTOES] FSM state per channel, channel i at [2i+1:2i]
// -----------------------------------------------------------------------------
module modulo_debounce_botoes
  import modulo_debounce_botoes_pkg::*;
#(
  parameter int NUM_BOTOES    = 2,
  parameter int TEMPO_ESTAVEL = TEMPO_ESTAVEL_50MHZ,
  parameter int ATIVO_BAIXO   = 1,
  parameter int CONT_W        = CONT_W_PADRAO
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NUM_BOTOES-1:0]   botao_in,
  output logic [NUM_BOTOES-1:0]   nivel_out,
  output logic [NUM_BOTOES-1:0]   pulso_out,
  output logic [NUM_BOTOES-1:0]   soltura_out,
  output logic [2*NUM_BOTOES-1:0] estado_dbg
);

  for (genvar i = 0; i < NUM_BOTOES; i++) begin : g_canal
    estado_t w_estado;

    modulo_debounce_canal #(
      .TEMPO_ESTAVEL (TEMPO_ESTAVEL),
      .ATIVO_BAIXO   (ATIVO_BAIXO),
      .CONT_W        (CONT_W)
    ) u_canal (
      .clk         (clk),
      .clr         (clr),
      .botao_in    (botao_in[i]),
      .nivel_out   (nivel_out[i]),
      .pulso_out   (pulso_out[i]),
      .soltura_out (soltura_out[i]),
      .estado_dbg  (w_estado)
    );

    assign estado_dbg[2*i +: 2] = w_estado;
  end

endmodule

// File: tb/tb_modulo_debounce_botoes.sv
// -----------------------------------------------------------------------------
// tb_modulo_debounce_botoes
// Drives raw key patterns, predicts outputs with a run-length model of the
// debouncer (the accepted level flips once TEMPO_ESTAVEL consecutive
// synchronised samples disagree with it) and compares every cycle.
// -----------------------------------------------------------------------------
module tb_modulo_debounce_botoes;

  localparam int TE = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [1:0] botao_in = 2'b11;
  logic [1:0] nivel_out, pulso_out, soltura_out;
  logic [3:0] estado_dbg;

  modulo_debounce_botoes #(
    .NUM_BOTOES    (2),
    .TEMPO_ESTAVEL (TE),
    .ATIVO_BAIXO   (1),
    .CONT_W        (19)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .botao_in    (botao_in),
    .nivel_out   (nivel_out),
    .pulso_out   (pulso_out),
    .soltura_out (soltura_out),
    .estado_dbg  (estado_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_q[$];

  // model: raw synchroniser copy, accepted level, disagreeing-sample run
  logic [1:0] m_s1, m_s2, m_lvl;
  int         m_run[2];

  int tick_no;
  int pul_cnt[2], sol_cnt[2], pul_tick[2], sol_tick[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1  = 2'b11;
    m_s2  = 2'b11;
    m_lvl = 2'b00;
    for (int i = 0; i < 2; i++) m_run[i] = 0;
  endtask

  task automatic clear_stats();
    tick_no = 0;
    for (int i = 0; i < 2; i++) begin
      pul_cnt[i] = 0; sol_cnt[i] = 0; pul_tick[i] = 0; sol_tick[i] = 0;
    end
  endtask

  // One clock: apply raw keys, step the model at the edge, compare #1 later.
  task automatic tick(input logic [1:0] raw);
    logic [1:0] e_pul, e_sol;
    logic       p;
    botao_in = raw;
    @(posedge clk);
    e_pul = 2'b00;
    e_sol = 2'b00;
    if (clr) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        p = ~m_s2[i];
        if (p != m_lvl[i]) m_run[i]++;
        else               m_run[i] = 0;
        if (m_run[i] == TE) begin
          m_lvl[i] = p;
          m_run[i] = 0;
          if (p) e_pul[i] = 1'b1;
          else   e_sol[i] = 1'b1;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
    exp_q.push_back({m_lvl, e_pul, e_sol});
    #1;
    tick_no++;
    chk("outs", {26'd0, nivel_out, pulso_out, soltura_out}, {26'd0, exp_q.pop_front()});
    for (int i = 0; i < 2; i++) begin
      if (pulso_out[i])   begin pul_cnt[i]++; pul_tick[i] = tick_no; end
      if (soltura_out[i]) begin sol_cnt[i]++; sol_tick[i] = tick_no; end
    end
  endtask

  task automatic ticks(input logic [1:0] raw, input int n);
    for (int k = 0; k < n; k++) tick(raw);
  endtask

  // Asynchronous clear taken between edges, held for one edge.
  task automatic pulse_clr(input string tag);
    clr = 1'b1;
    #1;
    model_reset();
    chk(tag, {26'd0, nivel_out, pulso_out, soltura_out}, 32'd0);
    chk({tag, "_state"}, {28'd0, estado_dbg}, 32'd0);
    tick(botao_in);
    clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    clear_stats();
    #1;
    chk("reset_outs", {26'd0, nivel_out, pulso_out, soltura_out}, 32'd0);

    // Keys held while in reset: nothing comes out until clr falls.
    ticks(2'b00, 3);
    chk("rst_no_level", {30'd0, nivel_out}, 32'd0);
    clr = 1'b0;
    clear_stats();
    ticks(2'b00, 10);
    chk("rst_pul_cnt0", pul_cnt[0], 1);
    chk("rst_pul_cnt1", pul_cnt[1], 1);
    chk("rst_pul_tick0", pul_tick[0], 6);
    chk("rst_pul_tick1", pul_tick[1], 6);

    // Release both.
    clear_stats();
    ticks(2'b11, 10);
    chk("rel_sol_tick0", sol_tick[0], 6);
    chk("rel_sol_cnt1", sol_cnt[1], 1);

    // Clean press on channel 0.
    clear_stats();
    ticks(2'b10, 10);
    chk("clean_pul_tick", pul_tick[0], 6);
    chk("clean_ch1_quiet", pul_cnt[1], 0);
    ticks(2'b11, 10);

    // Bounce: low 2, high 1, then low steady.
    clear_stats();
    ticks(2'b10, 2);
    tick(2'b11);
    chk("bounce_no_pulse", pul_cnt[0], 0);
    clear_stats();
    ticks(2'b10, 10);
    chk("bounce_pul_tick", pul_tick[0], 6);

    // Long hold, then release.
    ticks(2'b10, 1000);
    chk("hold_one_pulse", pul_cnt[0], 1);
    clear_stats();
    ticks(2'b11, 10);
    chk("hold_rel_tick", sol_tick[0], 6);
    chk("hold_rel_cnt", sol_cnt[0], 1);

    // Release glitch shorter than the window.
    ticks(2'b10, 10);
    clear_stats();
    ticks(2'b11, 3);
    ticks(2'b10, 10);
    chk("glitch_no_sol", sol_cnt[0], 0);
    chk("glitch_level", {31'd0, nivel_out[0]}, 32'd1);
    ticks(2'b11, 10);

    // Independence: channel 1 two cycles after channel 0.
    clear_stats();
    ticks(2'b10, 2);
    ticks(2'b00, 10);
    chk("indep_gap", pul_tick[1] - pul_tick[0], 2);
    ticks(2'b11, 10);

    // Clear while channel 0 is confirming (cnt=2 after 4 edges).
    clear_stats();
    ticks(2'b10, 4);
    chk("mid_state", {30'd0, estado_dbg[1:0]}, 32'd1);
    pulse_clr("mid_clr");
    chk("mid_no_pulse", pul_cnt[0], 0);
    clear_stats();
    ticks(2'b10, 10);
    chk("mid_restart_tick", pul_tick[0], 6);
    chk("mid_restart_cnt", pul_cnt[0], 1);

    // Asynchronous clear while a channel is fully pressed.
    ticks(2'b00, 10);
    chk("async_pre_level", {30'd0, nivel_out}, 32'd3);
    pulse_clr("async_clr");
    ticks(2'b11, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
